// File: rtl/saturation_pkg.sv
// Shared constants and enums for the saturation coefficient controller.
package saturation_pkg;
  localparam int COE_W_DEF = 16;

  // Power-on coefficient set {sat, ycoe0, ycoe1, ycoe2}
  localparam int RST_SAT   = 64;
  localparam int RST_YCOE0 = 19;
  localparam int RST_YCOE1 = 37;
  localparam int RST_YCOE2 = 9;

  typedef enum logic [1:0] {SAT = 2'd0, YCOE0 = 2'd1, YCOE1 = 2'd2, YCOE2 = 2'd3} cfg_addr_e;
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, RAMP = 2'd2} state_e;
endpackage

// File: rtl/saturation_ctrl_ramp.sv
// Saturation stepper: moves cur toward target by at most STEP, landing exactly on target.
module saturation_ctrl_ramp #(
  parameter int COE_W    = 16,
  parameter int SAT_STEP = 4
) (
  input  logic [COE_W-1:0] cur_i,
  input  logic [COE_W-1:0] target_i,
  output logic [COE_W-1:0] next_o,
  output logic             done_o
);
  localparam logic [COE_W-1:0] STEP = COE_W'(SAT_STEP);

  // Take a full step unless the remaining distance is within one step
  always_comb begin
    next_o = target_i;
    if (target_i > cur_i) begin
      if (target_i - cur_i > STEP) next_o = cur_i + STEP;
    end else if (cur_i - target_i > STEP) begin
      next_o = cur_i - STEP;
    end
  end

  assign done_o = (next_o == target_i);
endmodule

// File: rtl/saturation_ctrl.sv
// Frame-synchronous coefficient controller: host writes shadow regs, a commit arms
// an atomic shadow->active copy on the next vsync rising edge (or on timeout).
// Optional feature macro: SATURATION_CTRL_RAMP_EN (saturation ramps per frame).
module saturation_ctrl
  import saturation_pkg::*;
#(
  parameter int COE_W      = COE_W_DEF,
  parameter int COE_MULT   = 64,
  parameter int SAT_MAX    = 192,
  parameter int VS_TIMEOUT = 2**20,
  parameter int SAT_STEP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [COE_W-1:0] cfg_data_i,
  input  logic             cfg_commit_i,
  input  logic             vs_i,
  output logic [COE_W-1:0] saturation_o,
  output logic [COE_W-1:0] ycoe0_o,
  output logic [COE_W-1:0] ycoe1_o,
  output logic [COE_W-1:0] ycoe2_o,
  output logic             busy_o,
  output logic             apply_o,
  output logic             timeout_o
);
  localparam int CNT_W = (VS_TIMEOUT > 2) ? $clog2(VS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VS_TIMEOUT - 1);
  localparam logic [3:0][COE_W-1:0] RST_SET = {COE_W'(RST_YCOE2), COE_W'(RST_YCOE1),
                                               COE_W'(RST_YCOE0), COE_W'(COE_MULT)};

  // Index 0 = sat, 1..3 = ycoe0..2 (matches cfg_addr_e)
  logic [3:0][COE_W-1:0] shadow_q, active_q;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  vs_q, apply_q, timeout_q;
  logic                  vs_rise, cnt_hit, apply, forced, step, retarget;
  logic [COE_W-1:0]      wr_data;

  assign vs_rise = vs_i & ~vs_q;
  assign cnt_hit = (cnt_q == CNT_LAST);

  // Saturation writes clamp to SAT_MAX; luma coefficients pass through
  always_comb begin
    wr_data = cfg_data_i;
    if (cfg_addr_i == SAT && cfg_data_i > COE_W'(SAT_MAX)) wr_data = COE_W'(SAT_MAX);
  end

`ifdef SATURATION_CTRL_RAMP_EN
  logic [COE_W-1:0] target_q, ramp_tgt, ramp_next;
  logic             retgt_q, ramp_done;

  // A fresh apply or an armed retarget steps toward the shadow sat, else the held target
  assign ramp_tgt = (state_q == PEND || retgt_q) ? shadow_q[SAT] : target_q;

  saturation_ctrl_ramp #(.COE_W(COE_W), .SAT_STEP(SAT_STEP)) u_ramp (
    .cur_i    (active_q[SAT]),
    .target_i (ramp_tgt),
    .next_o   (ramp_next),
    .done_o   (ramp_done)
  );
`endif

  // Next-state and apply decode
  always_comb begin
    state_d  = state_q;
    apply    = 1'b0;
    forced   = 1'b0;
    step     = 1'b0;
    retarget = 1'b0;
    case (state_q)
      IDLE: if (cfg_commit_i) state_d = PEND;
      PEND: if (vs_rise || cnt_hit) begin
        apply  = 1'b1;
        forced = ~vs_rise;
`ifdef SATURATION_CTRL_RAMP_EN
        state_d = ramp_done ? IDLE : RAMP;
`else
        state_d = IDLE;
`endif
      end
`ifdef SATURATION_CTRL_RAMP_EN
      RAMP: if (vs_rise) begin
        step     = 1'b1;
        retarget = retgt_q;
        // A commit landing on the final step must not be lost
        if (ramp_done) state_d = cfg_commit_i ? PEND : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, shadow/active sets, timeout counter and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= RST_SET;
      active_q  <= RST_SET;
      cnt_q     <= '0;
      vs_q      <= 1'b0;
      apply_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SATURATION_CTRL_RAMP_EN
      target_q  <= COE_W'(COE_MULT);
      retgt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vs_q    <= vs_i;
      apply_q <= apply | step;
      if (cfg_wr_i) shadow_q[cfg_addr_i] <= wr_data;

      if (state_d == PEND && state_q != PEND) cnt_q <= '0;
      else if (state_q == PEND && !cnt_hit)   cnt_q <= cnt_q + 1'b1;

      if (apply) begin
        active_q[3:1] <= shadow_q[3:1];
        timeout_q     <= forced;
`ifdef SATURATION_CTRL_RAMP_EN
        active_q[SAT] <= ramp_next;
        target_q      <= shadow_q[SAT];
`else
        active_q[SAT] <= shadow_q[SAT];
`endif
      end

`ifdef SATURATION_CTRL_RAMP_EN
      if (step) begin
        active_q[SAT] <= ramp_next;
        if (retarget) begin
          target_q      <= shadow_q[SAT];
          active_q[3:1] <= shadow_q[3:1];
        end
      end
      // Commit during a ramp arms a retarget for the next frame edge
      if (step)                               retgt_q <= cfg_commit_i && state_d == RAMP;
      else if (state_q == RAMP && cfg_commit_i) retgt_q <= 1'b1;
`endif
    end
  end

  assign saturation_o = active_q[SAT];
  assign ycoe0_o      = active_q[YCOE0];
  assign ycoe1_o      = active_q[YCOE1];
  assign ycoe2_o      = active_q[YCOE2];
  assign busy_o       = (state_q != IDLE);
  assign apply_o      = apply_q;
  assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_saturation_ctrl.sv
// Scoreboard bench for saturation_ctrl: stimulus pushes the expected active set,
// the monitor pops and compares on every apply_o pulse.
module tb_saturation_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_i = 1'b0, cfg_commit_i = 1'b0, vs_i = 1'b0;
  logic [1:0]  cfg_addr_i = '0;
  logic [15:0] cfg_data_i = '0;
  logic [15:0] saturation_o, ycoe0_o, ycoe1_o, ycoe2_o;
  logic        busy_o, apply_o, timeout_o;

  typedef struct {
    logic [15:0] sat, y0, y1, y2;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  saturation_ctrl #(.COE_W(16), .COE_MULT(64), .SAT_MAX(192), .VS_TIMEOUT(16), .SAT_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .cfg_commit_i(cfg_commit_i), .vs_i(vs_i),
    .saturation_o(saturation_o), .ycoe0_o(ycoe0_o), .ycoe1_o(ycoe1_o), .ycoe2_o(ycoe2_o),
    .busy_o(busy_o), .apply_o(apply_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_wr_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    tk(1);
    cfg_wr_i = 1'b0;
  endtask

  task automatic commit();
    cfg_commit_i = 1'b1;
    tk(1);
    cfg_commit_i = 1'b0;
  endtask

  task automatic vs_pulse();
    vs_i = 1'b1;
    tk(1);
    vs_i = 1'b0;
    tk(2);
  endtask

  task automatic push(input int s, input int a, input int b, input int c, input logic t);
    exp_t e;
    e.sat = 16'(s); e.y0 = 16'(a); e.y1 = 16'(b); e.y2 = 16'(c); e.to = t;
    exp_q.push_back(e);
  endtask

  // Monitor: every apply pulse must match the oldest expected set
  always @(negedge clk) begin
    if (rst_n && apply_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_apply: got sat=%0d expected no apply", saturation_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("apply_sat", 32'(saturation_o), 32'(e.sat));
        chk("apply_y0",  32'(ycoe0_o), 32'(e.y0));
        chk("apply_y1",  32'(ycoe1_o), 32'(e.y1));
        chk("apply_y2",  32'(ycoe2_o), 32'(e.y2));
        chk("apply_to",  32'(timeout_o), 32'(e.to));
      end
    end
  end

  initial begin
    // Reset held two clocks
    tk(2);
    chk("rst_sat", 32'(saturation_o), 64);
    chk("rst_y0", 32'(ycoe0_o), 19);
    chk("rst_y1", 32'(ycoe1_o), 37);
    chk("rst_y2", 32'(ycoe2_o), 9);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_apply", 32'(apply_o), 0);
    rst_n = 1'b1;
    tk(1);

    // Commit then vs rise (kept under the 16-cycle timeout of this build)
    wr(0, 96);
    commit();
    chk("t2_busy", 32'(busy_o), 1);
    tk(10);
    chk("t2_sat_before", 32'(saturation_o), 64);
    chk("t2_no_apply", 32'(apply_o), 0);
    push(96, 19, 37, 9, 1'b0);
    vs_i = 1'b1;
    tk(1);
    chk("t2_sat_after", 32'(saturation_o), 96);
    vs_i = 1'b0;
    tk(1);
    chk("t2_pulse_single", 32'(apply_o), 0);
    chk("t2_busy_done", 32'(busy_o), 0);

    // Commit coincident with vs rise while idle; clamped sat write
    wr(0, 300);
    cfg_commit_i = 1'b1; vs_i = 1'b1;
    tk(1);
    cfg_commit_i = 1'b0; vs_i = 1'b0;
    tk(1);
    chk("t3_no_change", 32'(saturation_o), 96);
    chk("t3_pending", 32'(busy_o), 1);
    push(192, 19, 37, 9, 1'b0);
    vs_pulse();
    chk("t3_clamped", 32'(saturation_o), 192);

    // Write in the apply cycle stays in shadow only
    wr(1, 25);
    commit();
    cfg_wr_i = 1'b1; cfg_addr_i = 2'd1; cfg_data_i = 16'd50;
    push(192, 25, 37, 9, 1'b0);
    vs_i = 1'b1;
    tk(1);
    cfg_wr_i = 1'b0; vs_i = 1'b0;
    tk(2);
    commit();
    push(192, 50, 37, 9, 1'b0);
    vs_pulse();

    // Timeout: no vs, forced apply 16 clocks after commit
    wr(0, 100);
    commit();
    push(100, 50, 37, 9, 1'b1);
    tk(15);
    chk("t4_not_yet", 32'(apply_o), 0);
    chk("t4_busy", 32'(busy_o), 1);
    tk(1);
    chk("t4_apply", 32'(apply_o), 1);
    chk("t4_timeout", 32'(timeout_o), 1);
    tk(1);
    wr(0, 80);
    commit();
    chk("t4_sticky", 32'(timeout_o), 1);
    push(80, 50, 37, 9, 1'b0);
    vs_pulse();
    chk("t4_cleared", 32'(timeout_o), 0);

    // Reset while pending drops the commit
    wr(0, 150);
    commit();
    tk(3);
    rst_n = 1'b0;
    tk(2);
    rst_n = 1'b1;
    chk("t5_sat", 32'(saturation_o), 64);
    chk("t5_y0", 32'(ycoe0_o), 19);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_timeout", 32'(timeout_o), 0);
    vs_pulse();
    tk(2);
    chk("t5_no_apply_sat", 32'(saturation_o), 64);

    // Saturation 64 -> 74
    wr(0, 74);
    commit();
`ifdef SATURATION_CTRL_RAMP_EN
    push(68, 19, 37, 9, 1'b0);
    vs_pulse();
    chk("t6_step1", 32'(saturation_o), 68);
    chk("t6_busy1", 32'(busy_o), 1);
    push(72, 19, 37, 9, 1'b0);
    vs_pulse();
    chk("t6_step2", 32'(saturation_o), 72);
    push(74, 19, 37, 9, 1'b0);
    vs_pulse();
    chk("t6_step3", 32'(saturation_o), 74);
    chk("t6_busy_done", 32'(busy_o), 0);
`else
    push(74, 19, 37, 9, 1'b0);
    vs_pulse();
    chk("t6_jump", 32'(saturation_o), 74);
    chk("t6_busy_done", 32'(busy_o), 0);
`endif

    tk(5);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
